// File: rtl/mul_ternary_if.sv
// ---------------------------------------------------------------------------
// mul_ternary_if
//
// Streaming front-end for a parallel ternary polynomial multiplier.
//
// Flow:
// - Loads PARAM_N generic coefficients into poly_gen, reducing each one once
//   modulo PARAM_Q.
// - Loads PARAM_N ternary codes into poly_ter.
// - Starts the multiplier, waits for it to finish, then streams poly_res
//   back out.
// - Finally pulses a release command to the multiplier.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_start             begin a load phase (only honoured in IDLE)
//   cmd_neg_wrap          negacyclic select, captured with cmd_start
//   in_valid/in_ready/in_data      coefficient / ternary code input stream
//   out_valid/out_ready/out_data/out_last   result output stream
//   mul_enable, mul_start, mul_rst_cmd, mul_neg_wrap   multiplier control
//   poly_gen, poly_ter    flattened operand buses (entry k at [k*W +: W])
//   poly_res, mul_ready   flattened result bus and multiplier ready
//   busy                  high whenever the FSM is not IDLE
//   err_enc               sticky: a ternary code 2'b10 was received
//   err_timeout           sticky: the multiplier watchdog expired
//   o_dbg_state           current FSM state, for observation only
//
// Build option: define MUL_TERNARY_IF_TIMEOUT_EN to compile in the
// multiplier watchdog.
// - When it is defined, TIMEOUT_CYCLES cycles spent in WAIT_BUSY and
//   WAIT_DONE abort to RELEASE.
// - When it is undefined, the FSM waits indefinitely and err_timeout is
//   constant 0.
//
// Handshake semantics: a beat transfers on a rising edge where both valid
// and ready are high. Valid never depends on ready. While out_valid is high
// and out_ready is low, out_data and out_last hold their values.
// ---------------------------------------------------------------------------
module mul_ternary_if #(
    parameter int PARAM_N        = 512,
    parameter int PARAM_Q        = 251,
    parameter int PARAM_LOG_Q    = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_start,
    input  logic                           cmd_neg_wrap,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PARAM_LOG_Q-1:0]         in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PARAM_LOG_Q-1:0]         out_data,
    output logic                           out_last,
    output logic                           mul_enable,
    output logic                           mul_start,
    output logic                           mul_rst_cmd,
    output logic                           mul_neg_wrap,
    output logic [PARAM_N*PARAM_LOG_Q-1:0] poly_gen,
    output logic [PARAM_N*2-1:0]           poly_ter,
    input  logic [PARAM_N*PARAM_LOG_Q-1:0] poly_res,
    input  logic                           mul_ready,
    output logic                           busy,
    output logic                           err_enc,
    output logic                           err_timeout,
    output logic [2:0]                     o_dbg_state
);

    localparam int IDX_W = (PARAM_N > 1) ? $clog2(PARAM_N) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(PARAM_N - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
    localparam logic [PARAM_LOG_Q-1:0] Q_VAL    = PARAM_Q[PARAM_LOG_Q-1:0];

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_GEN  = 3'd1,
        S_LOAD_TER  = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_UNLOAD    = 3'd6,
        S_RELEASE   = 3'd7
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_neg_wrap;
    logic                   r_err_enc;
    logic [PARAM_LOG_Q-1:0] r_gen [PARAM_N];
    logic [1:0]             r_ter [PARAM_N];

    logic [PARAM_LOG_Q-1:0] w_res [PARAM_N];
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic [PARAM_LOG_Q-1:0] w_gen_red;
    logic [1:0]             w_ter_code;
    logic                   w_ter_bad;
    logic                   w_idx_last;

`ifdef MUL_TERNARY_IF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;
    logic            w_wd_expire;

    // The count reaches WD_LAST on the TIMEOUT_CYCLES-th wait cycle.
    assign w_wd_expire = (r_wd_cnt == WD_LAST);
    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    // Flatten register arrays onto the multiplier buses and unpack results.
    for (genvar g = 0; g < PARAM_N; g++) begin : g_flat
        assign poly_gen[g*PARAM_LOG_Q +: PARAM_LOG_Q] = r_gen[g];
        assign poly_ter[g*2 +: 2]                     = r_ter[g];
        assign w_res[g] = poly_res[g*PARAM_LOG_Q +: PARAM_LOG_Q];
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_idx_last = (r_idx == LAST_IDX);

    // A single conditional subtraction is enough: inputs are below 2*Q.
    assign w_gen_red  = (in_data >= Q_VAL) ? (in_data - Q_VAL) : in_data;

    // Code 2'b10 is not a valid ternary value; it is stored as zero.
    assign w_ter_bad  = (in_data[1:0] == 2'b10);
    assign w_ter_code = w_ter_bad ? 2'b00 : in_data[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_neg_wrap <= 1'b0;
            r_err_enc  <= 1'b0;
            for (int i = 0; i < PARAM_N; i++) begin
                r_gen[i] <= '0;
                r_ter[i] <= '0;
            end
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_state    <= S_LOAD_GEN;
                        r_idx      <= '0;
                        r_neg_wrap <= cmd_neg_wrap;
                        r_err_enc  <= 1'b0;
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                        r_err_timeout <= 1'b0;
`endif
                    end
                end

                S_LOAD_GEN: begin
                    if (w_in_fire) begin
                        r_gen[r_idx] <= w_gen_red;
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_LOAD_TER;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end

                S_LOAD_TER: begin
                    if (w_in_fire) begin
                        r_ter[r_idx] <= w_ter_code;
                        if (w_ter_bad) begin
                            r_err_enc <= 1'b1;
                        end
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_START;
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                            r_wd_cnt <= '0;
`endif
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end

                // mul_start is high for exactly this one cycle.
                S_START: begin
                    r_state <= S_WAIT_BUSY;
                end

                // Wait for the multiplier to drop ready. A ready that is
                // still high from the previous job does not mean done.
                S_WAIT_BUSY: begin
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                    r_wd_cnt <= r_wd_cnt + WD_ONE;
`endif
                    if (!mul_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_state       <= S_RELEASE;
                        r_err_timeout <= 1'b1;
                    end
`endif
                end

                S_WAIT_DONE: begin
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                    r_wd_cnt <= r_wd_cnt + WD_ONE;
`endif
                    if (mul_ready) begin
                        r_state <= S_UNLOAD;
                        r_idx   <= '0;
                    end
`ifdef MUL_TERNARY_IF_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_state       <= S_RELEASE;
                        r_err_timeout <= 1'b1;
                    end
`endif
                end

                S_UNLOAD: begin
                    if (w_out_fire) begin
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_RELEASE;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end

                // mul_rst_cmd is high for exactly this one cycle.
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Control outputs are decoded straight from the state register, so they
    // change only on clock edges.
    assign in_ready     = (r_state == S_LOAD_GEN) || (r_state == S_LOAD_TER);
    assign out_valid    = (r_state == S_UNLOAD);
    assign out_last     = (r_state == S_UNLOAD) && w_idx_last;
    assign out_data     = w_res[r_idx];
    assign mul_start    = (r_state == S_START);
    assign mul_rst_cmd  = (r_state == S_RELEASE);
    assign mul_enable   = (r_state == S_START)     || (r_state == S_WAIT_BUSY) ||
                          (r_state == S_WAIT_DONE) || (r_state == S_UNLOAD)    ||
                          (r_state == S_RELEASE);
    assign mul_neg_wrap = r_neg_wrap;
    assign busy         = (r_state != S_IDLE);
    assign err_enc      = r_err_enc;
    assign o_dbg_state  = r_state;

endmodule
